// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host receiver: synchronises and glitch-filters the PS/2 lines, deserialises
// 11-bit frames, checks parity/stop, and folds E0/F0 prefixes into single key events.
module ps2_frame_receiver #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DATA,
  output logic [7:0] oByte,
  output logic       oByteValid,
  output logic [7:0] oKeyCode,
  output logic       oKeyRelease,
  output logic       oKeyExtended,
  output logic       oKeyValid,
  output logic       oParityError,
  output logic       oFrameError
);

  localparam logic [3:0]  FiltLen  = 4'(FILTER_LEN);
  localparam logic [19:0] TmoLast  = 20'(TIMEOUT - 1);
  localparam logic [7:0]  KeyBreak = 8'hF0;
  localparam logic [7:0]  KeyExt   = 8'hE0;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [1:0]  clk_sync_q, data_sync_q;
  logic        clk_synced, data_synced;
  logic [3:0]  filt_cnt_q;
  logic        filt_clk_q;
  logic        fall_q;
  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shreg_q;
  logic        parity_q;
  logic [19:0] tmo_cnt_q;
  logic        rel_pend_q, ext_pend_q;
  logic        parity_ok;

  assign clk_synced  = clk_sync_q[1];
  assign data_synced = data_sync_q[1];
  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  assign parity_ok   = ^{shreg_q, parity_q};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], iPS2_CLK};
      data_sync_q <= {data_sync_q[0], iPS2_DATA};
    end
  end

  // Level flips only after FiltLen consecutive differing samples; fall_q marks a 1->0 flip.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      filt_cnt_q <= '0;
      filt_clk_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (filt_cnt_q == FiltLen) begin
        filt_clk_q <= ~filt_clk_q;
        filt_cnt_q <= '0;
        fall_q     <= filt_clk_q;
      end else if (clk_synced == filt_clk_q) begin
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      parity_q     <= 1'b0;
      tmo_cnt_q    <= '0;
      rel_pend_q   <= 1'b0;
      ext_pend_q   <= 1'b0;
      oByte        <= '0;
      oByteValid   <= 1'b0;
      oKeyCode     <= '0;
      oKeyRelease  <= 1'b0;
      oKeyExtended <= 1'b0;
      oKeyValid    <= 1'b0;
      oParityError <= 1'b0;
      oFrameError  <= 1'b0;
    end else begin
      oByteValid   <= 1'b0;
      oKeyValid    <= 1'b0;
      oParityError <= 1'b0;
      oFrameError  <= 1'b0;
      if (fall_q) begin
        // A fall always wins over a coinciding timeout.
        tmo_cnt_q <= '0;
        unique case (state_q)
          StIdle: begin
            if (!data_synced) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
          StData: begin
            shreg_q   <= {data_synced, shreg_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= StParity;
            end
          end
          StParity: begin
            parity_q <= data_synced;
            state_q  <= StStop;
          end
          StStop: begin
            state_q <= StIdle;
            if (!data_synced) begin
              oFrameError <= 1'b1;
              rel_pend_q  <= 1'b0;
              ext_pend_q  <= 1'b0;
            end else if (!parity_ok) begin
              oParityError <= 1'b1;
              rel_pend_q   <= 1'b0;
              ext_pend_q   <= 1'b0;
            end else begin
              oByte      <= shreg_q;
              oByteValid <= 1'b1;
              if (shreg_q == KeyBreak) begin
                rel_pend_q <= 1'b1;
              end else if (shreg_q == KeyExt) begin
                ext_pend_q <= 1'b1;
              end else begin
                oKeyCode     <= shreg_q;
                oKeyRelease  <= rel_pend_q;
                oKeyExtended <= ext_pend_q;
                oKeyValid    <= 1'b1;
                rel_pend_q   <= 1'b0;
                ext_pend_q   <= 1'b0;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end else if (state_q != StIdle) begin
        if (tmo_cnt_q == TmoLast) begin
          oFrameError <= 1'b1;
          state_q     <= StIdle;
          tmo_cnt_q   <= '0;
          rel_pend_q  <= 1'b0;
          ext_pend_q  <= 1'b0;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 20'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Randomised bench for ps2_frame_receiver: a frame-level model predicts the cycle and content
// of every pulse and the held outputs, and a compare process checks all outputs every cycle.
module tb_ps2_frame_receiver;

  localparam int unsigned FL   = 4;
  localparam int unsigned TO   = 300;
  localparam int          HALF = 20;
  localparam int          GAP  = 30;
  // Edges from the first sampling edge after a line fall to the registered response pulse.
  localparam int          LAT  = FL + 3;

  typedef struct {
    int         cyc;
    bit         bv;
    bit         kv;
    bit         pe;
    bit         fe;
    logic [7:0] b;
    logic       rel;
    logic       ext;
  } ev_t;

  logic       Clock;
  logic       Reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] byte_o;
  logic [7:0] key_o;
  logic       bv_o, rel_o, ext_o, kv_o, pe_o, fe_o;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  ev_t  evq[$];
  logic [7:0] h_byte = 8'h00;
  logic [7:0] h_key  = 8'h00;
  logic       h_rel  = 1'b0;
  logic       h_ext  = 1'b0;
  logic       rel_pend = 1'b0;
  logic       ext_pend = 1'b0;
  int   bv_seen = 0, kv_seen = 0, pe_seen = 0, fe_seen = 0;

  ps2_frame_receiver #(
    .FILTER_LEN(FL),
    .TIMEOUT   (TO)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iPS2_CLK    (ps2_clk),
    .iPS2_DATA   (ps2_data),
    .oByte       (byte_o),
    .oByteValid  (bv_o),
    .oKeyCode    (key_o),
    .oKeyRelease (rel_o),
    .oKeyExtended(ext_o),
    .oKeyValid   (kv_o),
    .oParityError(pe_o),
    .oFrameError (fe_o)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    forever begin
      @(posedge Clock);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_cycle();
    ev_t e;
    bit ebv, ekv, epe, efe;
    ebv = 0; ekv = 0; epe = 0; efe = 0;
    if (!Reset && evq.size() > 0) begin
      if (evq[0].cyc == cyc) begin
        e = evq.pop_front();
        ebv = e.bv; ekv = e.kv; epe = e.pe; efe = e.fe;
        if (e.bv) h_byte = e.b;
        if (e.kv) begin
          h_key = e.b;
          h_rel = e.rel;
          h_ext = e.ext;
        end
      end else if (evq[0].cyc < cyc) begin
        e = evq.pop_front();
        check("event_missed_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    check("byte_valid", bv_o, ebv);
    check("key_valid", kv_o, ekv);
    check("parity_error", pe_o, epe);
    check("frame_error", fe_o, efe);
    check("byte", byte_o, h_byte);
    check("key_code", key_o, h_key);
    check("key_release", rel_o, h_rel);
    check("key_extended", ext_o, h_ext);
  endtask

  initial begin
    forever begin
      @(negedge Clock);
      compare_cycle();
      if (bv_o) bv_seen++;
      if (kv_o) kv_seen++;
      if (pe_o) pe_seen++;
      if (fe_o) fe_seen++;
    end
  end

  initial begin
    repeat (90000) @(posedge Clock);
    $display("FAIL watchdog: bench did not finish within cycle budget");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // Drives nbits of a frame (bit 0 first); optionally queues ev timed from the last clock fall.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit,
                           input bit push, input ev_t ev_in, input int extra);
    ev_t ev;
    ev = ev_in;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        step(8);
        ps2_clk = 1'b0;
        step(FL - 1);
        ps2_clk = 1'b1;
        step(HALF - 8 - (FL - 1));
      end else begin
        step(HALF);
      end
      ps2_clk = 1'b0;
      if (push && i == nbits - 1) begin
        ev.cyc = cyc + 1 + LAT + extra;
        evq.push_back(ev);
      end
      step(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                       input int glitch_bit);
    ev_t ev;
    logic p;
    ev.cyc = 0; ev.bv = 0; ev.kv = 0; ev.pe = 0; ev.fe = 0;
    ev.b = b; ev.rel = 0; ev.ext = 0;
    p = ~(^b) ^ bad_par;
    if (bad_stop) begin
      ev.fe = 1;
      rel_pend = 0;
      ext_pend = 0;
    end else if (bad_par) begin
      ev.pe = 1;
      rel_pend = 0;
      ext_pend = 0;
    end else begin
      ev.bv = 1;
      if (b == 8'hF0) rel_pend = 1;
      else if (b == 8'hE0) ext_pend = 1;
      else begin
        ev.kv  = 1;
        ev.rel = rel_pend;
        ev.ext = ext_pend;
        rel_pend = 0;
        ext_pend = 0;
      end
    end
    send_bits({~bad_stop, p, b, 1'b0}, 11, glitch_bit, 1'b1, ev, 0);
    step(GAP);
  endtask

  task automatic timeout_frame(input logic [3:0] nib);
    ev_t ev;
    ev.cyc = 0; ev.bv = 0; ev.kv = 0; ev.pe = 0; ev.fe = 1;
    ev.b = 8'h00; ev.rel = 0; ev.ext = 0;
    rel_pend = 0;
    ext_pend = 0;
    send_bits({6'b111111, nib, 1'b0}, 5, -1, 1'b1, ev, TO);
    step(TO + GAP);
  endtask

  task automatic reset_mid_frame(input logic [7:0] b, input int nbits);
    ev_t ev;
    ev.cyc = 0; ev.bv = 0; ev.kv = 0; ev.pe = 0; ev.fe = 0;
    ev.b = 8'h00; ev.rel = 0; ev.ext = 0;
    send_bits({2'b11, b, 1'b0}, nbits, -1, 1'b0, ev, 0);
    Reset = 1'b1;
    evq.delete();
    h_byte = 8'h00; h_key = 8'h00; h_rel = 1'b0; h_ext = 1'b0;
    rel_pend = 0; ext_pend = 0;
    step(3);
    Reset = 1'b0;
    step(GAP);
  endtask

  initial begin
    int n0, kv0, bv0, pe0, fe0;
    logic [7:0] rb;
    int r;
    Reset    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    #1 Reset = 1'b1;
    step(3);
    check("reset_byte", byte_o, 8'h00);
    check("reset_valid", {bv_o, kv_o, pe_o, fe_o, rel_o, ext_o}, 6'b0);
    Reset = 1'b0;
    step(10);

    // Single make code.
    frame(8'h1C, 0, 0, -1);
    check("t1_byte", byte_o, 8'h1C);
    check("t1_key", key_o, 8'h1C);
    check("t1_relext", {rel_o, ext_o}, 2'b00);
    check("t1_counts", {8'(bv_seen), 8'(kv_seen)}, {8'd1, 8'd1});

    // Break followed by make.
    kv0 = kv_seen; bv0 = bv_seen;
    frame(8'hF0, 0, 0, -1);
    frame(8'h1C, 0, 0, -1);
    check("t2_release", rel_o, 1'b1);
    frame(8'h1C, 0, 0, -1);
    check("t2_release_cleared", rel_o, 1'b0);
    check("t2_kv", kv_seen - kv0, 2);
    check("t2_bv", bv_seen - bv0, 3);

    // Extended break.
    kv0 = kv_seen;
    frame(8'hE0, 0, 0, -1);
    frame(8'hF0, 0, 0, -1);
    frame(8'h74, 0, 0, -1);
    check("t3_key", {key_o, rel_o, ext_o}, {8'h74, 2'b11});
    check("t3_kv", kv_seen - kv0, 1);

    // Parity error drops a pending break.
    kv0 = kv_seen; pe0 = pe_seen;
    frame(8'hF0, 0, 0, -1);
    frame(8'h1C, 1, 0, -1);
    check("t4_pe", pe_seen - pe0, 1);
    check("t4_no_kv", kv_seen - kv0, 0);
    frame(8'h29, 0, 0, -1);
    check("t4_key", {key_o, rel_o, ext_o}, {8'h29, 2'b00});

    // Inter-bit timeout, then recovery.
    fe0 = fe_seen;
    timeout_frame(4'hA);
    check("t5_fe", fe_seen - fe0, 1);
    frame(8'h29, 0, 0, -1);
    check("t5_key", key_o, 8'h29);

    // Short clock glitch while idle.
    n0 = bv_seen + kv_seen + pe_seen + fe_seen;
    ps2_clk = 1'b0;
    step(FL - 1);
    ps2_clk = 1'b1;
    step(GAP);
    check("t6_glitch_quiet", bv_seen + kv_seen + pe_seen + fe_seen, n0);

    // Reset after bit 5, then a clean frame.
    reset_mid_frame(8'h55, 6);
    check("t6_reset_outs", {byte_o, key_o, bv_o, kv_o, pe_o, fe_o, rel_o, ext_o}, 22'h0);
    frame(8'h5A, 0, 0, -1);
    check("t6_after_reset", {byte_o, key_o}, {8'h5A, 8'h5A});

    // Randomised traffic.
    for (int it = 0; it < 45; it++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        reset_mid_frame(8'($urandom), $urandom_range(1, 10));
      end else if (r < 12) begin
        timeout_frame(4'($urandom));
      end else if (r < 18) begin
        ps2_clk = 1'b0;
        step($urandom_range(1, FL - 1));
        ps2_clk = 1'b1;
        step(GAP);
      end else begin
        r = $urandom_range(0, 99);
        if (r < 25) rb = 8'hF0;
        else if (r < 40) rb = 8'hE0;
        else rb = 8'($urandom);
        frame(rb, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : -1);
      end
    end

    step(50);
    check("queue_drained", evq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
